wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the WB stage and a
//            buffered long-latency-unit result queue, with starvation stall.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         MEMWB_valid,
    input  logic                         RegWriteW,
    input  logic [4:0]                   RdW,
    input  logic [XLEN-1:0]              ResultW,
    input  logic                         lu_valid,
    input  logic [4:0]                   lu_rd,
    input  logic [XLEN-1:0]              lu_data,
    output logic                         lu_ready,
    input  logic [4:0]                   q_rs1,
    input  logic [4:0]                   q_rs2,
    input  logic [4:0]                   q_rd,
    output logic                         pend_hit,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic                         stall_req,
    output logic [$clog2(DEPTH+1)-1:0]   lu_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [PW-1:0] c_last_ptr   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth_cnt  = CW'(DEPTH);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;
    logic            r_stall;

    logic w_pipe_wr;
    logic w_empty;
    logic w_enq;
    logic w_deq;

    function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign w_pipe_wr = MEMWB_valid & RegWriteW & (RdW != 5'd0);
    assign w_empty   = (r_count == '0);
    assign lu_ready  = rst & (r_count < c_depth_cnt);
    // rd==0 results complete the handshake but are dropped here
    assign w_enq     = lu_valid & lu_ready & (lu_rd != 5'd0);
    assign w_deq     = rst & ~w_pipe_wr & ~w_empty;

    assign lu_count  = r_count;
    assign stall_req = r_stall;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst) begin
            if (w_pipe_wr) begin
                rf_we    = 1'b1;
                rf_waddr = RdW;
                rf_wdata = ResultW;
            end else if (!w_empty) begin
                rf_we    = 1'b1;
                rf_waddr = r_rd[r_rd_ptr];
                rf_wdata = r_data[r_rd_ptr];
            end
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] &&
                (((q_rs1 != 5'd0) && (q_rs1 == r_rd[i])) ||
                 ((q_rs2 != 5'd0) && (q_rs2 == r_rd[i])) ||
                 ((q_rd  != 5'd0) && (q_rd  == r_rd[i])))) begin
                pend_hit = 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rd[r_wr_ptr]   <= lu_rd;
            r_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= f_ptr_next(r_wr_ptr);
            end
            if (w_deq) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= f_ptr_next(r_rd_ptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_deq) begin
                r_starve <= '0;
            end else if (r_starve != c_starve_max) begin
                r_starve <= r_starve + 1'b1;
            end
            r_stall <= (r_starve == c_starve_max) & ~w_deq;
        end
    end

endmodule
`default_nettype wire
